// File: rtl/alu_pkg.sv
// Shared ALU package: divider state encoding, datapath width and the
// divide-by-zero quotient constant.
package alu_pkg;

    localparam int DIV_W = 32;

    // Quotient reported when the divisor is zero.
    localparam logic [DIV_W-1:0] QUOT_DIV0 = '1;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_ZERO = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/add_sub_32.sv
// Single-cycle adder/subtractor. sel=0: a+b, sel=1: a-b.
// cout is the carry out of the top bit; on subtract, 1 means no borrow.
module add_sub_32 #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sel,
    output logic [W-1:0] result,
    output logic         cout
);

    logic [W-1:0] b_eff;

    // Subtract as a + ~b + 1 so one carry chain serves both operations.
    always_comb begin
        b_eff = sel ? ~b : b;
        {cout, result} = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, sel};
    end

endmodule

// File: rtl/seq_divider_32.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Optional signed operation is enabled by defining DIV_SIGNED_EN.
//
// Handshake: start is sampled only in IDLE; an accepted start latches the
// operands, busy rises the following cycle and stays high until done.
// done is a one-cycle pulse with quotient/remainder/div_zero valid; those
// outputs then hold until the next request's own done. start seen while
// busy or during the done cycle is dropped, never queued.
module seq_divider_32
    import alu_pkg::*;
#(
    parameter int N     = DIV_W,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_zero,
    output logic [1:0]   dbg_state
);

    div_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0]     rem_w;    // partial remainder
    logic [N-1:0]     quo_w;    // dividend shifting out, quotient shifting in
    logic [N-1:0]     dvs_w;    // latched divisor magnitude

    logic [N-1:0]     dvd_in;
    logic [N-1:0]     dvs_in;
    logic [N-1:0]     r_shift;
    logic [N-1:0]     t_diff;
    logic             t_cout;
    logic             no_borrow;
    logic [N-1:0]     rem_next;
    logic [N-1:0]     quo_next;
    logic [N-1:0]     quo_out;
    logic [N-1:0]     rem_out;

`ifdef DIV_SIGNED_EN
    logic             neg_q;
    logic             neg_r;
`endif

    assign dbg_state = state;

    // Operand magnitudes taken at accept; plain pass-through when unsigned.
    always_comb begin
`ifdef DIV_SIGNED_EN
        dvd_in = dividend[N-1] ? -dividend : dividend;
        dvs_in = divisor[N-1]  ? -divisor  : divisor;
`else
        dvd_in = dividend;
        dvs_in = divisor;
`endif
    end

    // Shifted remainder R' = {rem_w, next dividend bit}; its bit N lives in
    // rem_w[N-1], so the N+1 bit trial is non-negative when that bit is set
    // or the N-bit subtract did not borrow.
    assign r_shift = {rem_w[N-2:0], quo_w[N-1]};

    add_sub_32 #(.W(N)) u_trial_sub (
        .a      (r_shift),
        .b      (dvs_w),
        .sel    (1'b1),
        .result (t_diff),
        .cout   (t_cout)
    );

    // Keep the trial difference or restore, and shift in the quotient bit.
    always_comb begin
        no_borrow = rem_w[N-1] | t_cout;
        rem_next  = no_borrow ? t_diff : r_shift;
        quo_next  = {quo_w[N-2:0], no_borrow};
`ifdef DIV_SIGNED_EN
        quo_out   = neg_q ? -quo_next : quo_next;
        rem_out   = neg_r ? -rem_next : rem_next;
`else
        quo_out   = quo_next;
        rem_out   = rem_next;
`endif
    end

    // Control FSM, iteration counter, working registers and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= DIV_IDLE;
            cnt       <= '0;
            rem_w     <= '0;
            quo_w     <= '0;
            dvs_w     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIV_SIGNED_EN
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            case (state)
                DIV_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy  <= 1'b1;
                        rem_w <= '0;
                        dvs_w <= dvs_in;
`ifdef DIV_SIGNED_EN
                        neg_q <= dividend[N-1] ^ divisor[N-1];
                        neg_r <= dividend[N-1];
`endif
                        if (divisor == '0) begin
                            // Raw dividend is parked here to become the remainder.
                            quo_w <= dividend;
                            state <= DIV_ZERO;
                        end else begin
                            quo_w <= dvd_in;
                            cnt   <= CNT_W'(N);
                            state <= DIV_RUN;
                        end
                    end
                end
                DIV_RUN: begin
                    rem_w <= rem_next;
                    quo_w <= quo_next;
                    cnt   <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        quotient  <= quo_out;
                        remainder <= rem_out;
                        div_zero  <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DIV_DONE;
                    end
                end
                DIV_ZERO: begin
                    quotient  <= N'(QUOT_DIV0);
                    remainder <= quo_w;
                    div_zero  <= 1'b1;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= DIV_DONE;
                end
                DIV_DONE: begin
                    done  <= 1'b0;
                    state <= DIV_IDLE;
                end
                default: begin
                    state <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_32.sv
// Self-checking bench for seq_divider_32: directed cases, reset abort,
// ignored re-starts, and random operands against a / and % reference.
module tb_seq_divider_32;
    import alu_pkg::*;

    localparam int W       = 32;
    localparam int LAT_RUN = W + 1;
    localparam int LAT_DZ  = 2;
    localparam int TIMEOUT = 80;
    localparam int N_RAND  = 1200;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;
    logic [1:0]   dbg_state;

    int errors = 0;
    int checks = 0;

    // {div_zero, quotient, remainder}
    logic [2*W:0] exp_q[$];
    logic [2*W:0] last_res;

    seq_divider_32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .dbg_state (dbg_state)
    );

    // Clock and time bound.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [2*W:0] obs, input logic [2*W:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: division defined by its arithmetic result, not by iteration.
    function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q;
        logic [W-1:0] r;
        if (b == 0) return {1'b1, {W{1'b1}}, a};
`ifdef DIV_SIGNED_EN
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, a, {W{1'b0}}};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
`else
        q = a / b;
        r = a % b;
`endif
        return {1'b0, q, r};
    endfunction

    // Issue one request and drive start for exactly one cycle at the negedge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // Full transaction. poke>0: pulse start with junk operands at that cycle
    // of the run. poke<0: pulse start during the done cycle.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int poke, input string tag);
        logic [2*W:0] exp_res;
        logic [2*W:0] got;
        int lat;
        bit seen;
        exp_q.push_back(ref_div(a, b));
        launch(a, b);
        lat  = 0;
        seen = 0;
        while (!seen && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
            if (done) begin
                seen = 1;
            end else begin
                start = 1'b0;
                if (lat == 1) check({tag, "_busy"}, {{(2*W){1'b0}}, busy}, 1);
                if (poke > 0 && lat == poke) begin
                    check({tag, "_held"}, {div_zero, quotient, remainder}, last_res);
                    start    = 1'b1;
                    dividend = $urandom;
                    divisor  = $urandom_range(1, 50);
                end
            end
        end
        start = 1'b0;
        check({tag, "_lat"}, lat, (b == 0) ? LAT_DZ : LAT_RUN);
        exp_res = exp_q.pop_front();
        got = {div_zero, quotient, remainder};
        check({tag, "_res"}, got, exp_res);
        last_res = exp_res;
        if (poke < 0) begin
            start    = 1'b1;
            dividend = 32'd77;
            divisor  = 32'd3;
        end
        @(negedge clk);
        start = 1'b0;
        check({tag, "_pulse"}, {{(2*W){1'b0}}, done}, 0);
        if (poke < 0) begin
            @(negedge clk);
            check({tag, "_ign"}, {{(2*W){1'b0}}, busy}, 0);
            check({tag, "_ignres"}, {div_zero, quotient, remainder}, last_res);
        end
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int dcount;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        last_res = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", dbg_state, DIV_IDLE);
        check("rst_out", {div_zero, quotient, remainder}, '0);
        check("rst_flags", {busy, done}, 0);
        rst_n = 1'b1;

        // Directed cases.
        run_div(32'd100, 32'd7, 0, "t1_100_7");
        check("t1_const", {div_zero, quotient, remainder}, {1'b0, 32'd14, 32'd2});
        run_div(32'hFFFF_FFFF, 32'd1, 0, "t2_max_1");
        check("t2_const", {div_zero, quotient, remainder}, {1'b0, 32'hFFFF_FFFF, 32'd0});
        run_div(32'd5, 32'd9, 0, "t2_5_9");
        check("t2b_const", {div_zero, quotient, remainder}, {1'b0, 32'd0, 32'd5});
        run_div(32'h1234, 32'd0, 0, "t3_div0");
        check("t3_const", {div_zero, quotient, remainder}, {1'b1, 32'hFFFF_FFFF, 32'h1234});
        run_div(32'd100, 32'd7, 10, "t4_repulse");
        run_div(32'd1000, 32'd3, -1, "t4_startdone");
        run_div(32'd0, 32'd5, 0, "edge_zero_dvd");
        run_div(32'd6, 32'd6, 0, "edge_equal");
        run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "edge_max_max");
        run_div(32'd3, 32'hFFFF_FFFE, 0, "edge_small_big");
        run_div(32'h8000_0001, 32'h8000_0000, 0, "edge_msb");

`ifdef DIV_SIGNED_EN
        run_div(-32'sd7, 32'd2, 0, "t6_m7_2");
        check("t6_const", {div_zero, quotient, remainder}, {1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF});
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 0, "t6_ovf");
        check("t6b_const", {div_zero, quotient, remainder}, {1'b0, 32'h8000_0000, 32'd0});
        run_div(32'd7, -32'sd2, 0, "s_7_m2");
        run_div(-32'sd9, 32'd0, 0, "s_div0_neg");
`endif

        // Reset in the middle of a run aborts with no done pulse.
        launch(32'd1000, 32'd3);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("t5_state", dbg_state, DIV_IDLE);
        check("t5_out", {div_zero, quotient, remainder}, '0);
        check("t5_flags", {busy, done}, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        dcount = 0;
        repeat (LAT_RUN + 5) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("t5_nodone", dcount, 0);
        last_res = '0;

        // Random operands, varied divisor classes.
        for (int i = 0; i < N_RAND; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 16);
                2: rb = $urandom & 32'h0000_FFFF;
                3: rb = ra >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            run_div(ra, rb, 0, "rand");
        end

        check("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
